// File: rtl/security_key_ctrl_if.sv
// Handshake bundle between the key/data source and security_key_ctrl.
// The master drives key attempts and data words; the slave returns grants, staged data and status.
interface security_key_ctrl_if;
    logic        key_valid;
    logic [15:0] key_in;
    logic        key_target;
    logic        data_valid;
    logic [31:0] data_in;
    logic        enc_req;
    logic [15:0] key_access_mem;
    logic [15:0] key_access_reg;
    logic        encryption_on;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_drop;
    logic        locked;
    logic [3:0]  fail_count;

    modport master (
        output key_valid, key_in, key_target, data_valid, data_in, enc_req,
        input  key_access_mem, key_access_reg, encryption_on, data_out,
               data_out_valid, data_drop, locked, fail_count
    );

    modport slave (
        input  key_valid, key_in, key_target, data_valid, data_in, enc_req,
        output key_access_mem, key_access_reg, encryption_on, data_out,
               data_out_valid, data_drop, locked, fail_count
    );
endinterface

// File: rtl/security_key_ctrl.sv
// Key authentication, grant/lockout FSM and data staging in front of the security stage.
// All outputs come from registers; grant-derived outputs follow the state after each edge.
module security_key_ctrl #(
    parameter logic [15:0] KEY          = 16'h0032,
    parameter int          MAX_FAILS    = 3,
    parameter int          LOCK_CYCLES  = 16,
    parameter int          GRANT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    security_key_ctrl_if.slave bus
);
    localparam int TMAX = (LOCK_CYCLES > GRANT_CYCLES) ? LOCK_CYCLES : GRANT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT_MEM = 2'd1,
        ST_GRANT_REG = 2'd2,
        ST_LOCKED    = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [3:0]     fail_q, fail_d;
    logic [15:0]    kam_q, kar_q;
    logic [31:0]    dout_q;
    logic           enc_q, dov_q, drop_q, locked_q;
    logic           key_ok_s, grant_next_s;
    logic [3:0]     fail_inc_s;
    state_e         target_s;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v == 4'd15) begin
            return 4'd15;
        end else begin
            return v + 4'd1;
        end
    endfunction

    // Next-state logic: one shared timer serves as grant timer or lock timer.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        fail_d     = fail_q;
        key_ok_s   = (bus.key_in == KEY);
        fail_inc_s = sat_inc(fail_q);
        target_s   = bus.key_target ? ST_GRANT_REG : ST_GRANT_MEM;
        case (state_q)
            ST_IDLE, ST_GRANT_MEM, ST_GRANT_REG: begin
                if (bus.key_valid) begin
                    if (key_ok_s) begin
                        state_d = target_s;
                        timer_d = TW'(GRANT_CYCLES);
                        fail_d  = 4'd0;
                    end else if (fail_inc_s == 4'(MAX_FAILS)) begin
                        state_d = ST_LOCKED;
                        timer_d = TW'(LOCK_CYCLES);
                        fail_d  = fail_inc_s;
                    end else begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                        fail_d  = fail_inc_s;
                    end
                end else if (state_q == ST_IDLE) begin
                    state_d = ST_IDLE;
                end else if (bus.data_valid) begin
                    timer_d = TW'(GRANT_CYCLES);
                end else if (timer_q <= TW'(1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_LOCKED: begin
                // Key attempts are ignored entirely while locked out.
                if (timer_q <= TW'(1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    fail_d  = 4'd0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                fail_d  = 4'd0;
            end
        endcase
        grant_next_s = (state_d == ST_GRANT_MEM) || (state_d == ST_GRANT_REG);
    end

    // State, timer and fail counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            fail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
        end
    end

    // Output registers; data is staged only when the post-edge state is a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            kam_q    <= 16'h0000;
            kar_q    <= 16'h0000;
            dout_q   <= 32'h0000_0000;
            enc_q    <= 1'b0;
            dov_q    <= 1'b0;
            drop_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            kam_q    <= (state_d == ST_GRANT_MEM) ? KEY : 16'h0000;
            kar_q    <= (state_d == ST_GRANT_REG) ? KEY : 16'h0000;
            locked_q <= (state_d == ST_LOCKED);
            dov_q    <= bus.data_valid && grant_next_s;
            drop_q   <= bus.data_valid && !grant_next_s;
            if (bus.data_valid && grant_next_s) begin
                dout_q <= bus.data_in;
                enc_q  <= bus.enc_req;
            end else begin
                dout_q <= dout_q;
                enc_q  <= enc_q;
            end
        end
    end

    assign bus.key_access_mem = kam_q;
    assign bus.key_access_reg = kar_q;
    assign bus.encryption_on  = enc_q;
    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dov_q;
    assign bus.data_drop      = drop_q;
    assign bus.locked         = locked_q;
    assign bus.fail_count     = fail_q;
endmodule
